vga_timing: RTL and testbench

// - Generates VGA raster timing downstream of the icevga clock divider.
// - Consumes the 48 MHz SB_HFOSC clock plus a one-cycle pixel enable from the divider.
// - Produces hsync/vsync, an active-video flag, pixel coordinates and a frame-start strobe.
// - These outputs feed the pixel-fetch/colour stage and the board's VGA pins.
//

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/vga_axis_counter.sv | 78 +++++++
 rtl/vga_timing.sv | 139 +++++++++++++
 tb/tb_vga_timing.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared definitions for the VGA raster timing block.
// - phase_e : the four per-axis raster phases. The encoding is fixed so
//             other stages that decode phase bits directly stay compatible.
// - DEF_*   : default 640x480 @ 60 Hz timing constants, in pixels and lines.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One raster axis: a position counter plus its ACTIVE/FRONT/SYNC/BACK phase
// FSM. The same module serves the horizontal axis (stepped per pixel) and
// the vertical axis (stepped once per line).
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active high; parks the axis on its
//                   last count in BACK, so the first step lands on 0/ACTIVE
//   step       in   advance one position on this clock edge
//   count      out  current position, 0..TOTAL-1
//   phase      out  current phase
//   nextPhase  out  phase after this edge, so the parent can register
//                   decoded outputs that change on the same edge as count
//   wrap       out  count sits on TOTAL-1; the next step returns to 0
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FRONT  = 16,
  parameter int SYNC   = 96,
  parameter int BACK   = 48,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] count,
  output logic [1:0]   phase,
  output logic [1:0]   nextPhase,
  output logic         wrap
);

  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

  // Last count of each phase, at counter width, so every compare is a
  // plain unsigned equality with no overflow path.
  localparam logic [W-1:0] ACTIVE_LAST = W'(ACTIVE - 1);
  localparam logic [W-1:0] FRONT_LAST  = W'(ACTIVE + FRONT - 1);
  localparam logic [W-1:0] SYNC_LAST   = W'(ACTIVE + FRONT + SYNC - 1);
  localparam logic [W-1:0] TOTAL_LAST  = W'(TOTAL - 1);

  logic [W-1:0] count_q, count_d;
  phase_e       phase_q, phase_d;

  // Next-state logic: on a step the counter advances (wrapping at the end
  // of the back porch) and the phase moves on when the counter sits on the
  // last count of the current phase.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (step) begin
      count_d = (count_q == TOTAL_LAST) ? '0 : count_q + W'(1);
      case (phase_q)
        PH_ACTIVE: if (count_q == ACTIVE_LAST) phase_d = PH_FRONT;
        PH_FRONT:  if (count_q == FRONT_LAST)  phase_d = PH_SYNC;
        PH_SYNC:   if (count_q == SYNC_LAST)   phase_d = PH_BACK;
        PH_BACK:   if (count_q == TOTAL_LAST)  phase_d = PH_ACTIVE;
      endcase
    end
  end

  // State registers; reset parks the axis on the final back-porch count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= TOTAL_LAST;
      phase_q <= PH_BACK;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count     = count_q;
  assign phase     = phase_q;
  assign nextPhase = phase_d;
  assign wrap      = (count_q == TOTAL_LAST);

endmodule

// File: rtl/vga_timing.sv
// vga_timing
// VGA raster timing generator. It runs on the 48 MHz system clock and
// advances one pixel on each clock where pix_en (from the clock divider) is
// high.
// Ports:
//   clk          in   48 MHz system clock
//   rst          in   asynchronous reset, active high
//   pix_en       in   pixel advance strobe
//   hsync        out  horizontal sync, registered, asserted level HSYNC_POL
//   vsync        out  vertical sync, registered, asserted level VSYNC_POL
//   active       out  inside the visible area
//   x, y         out  raster position
//   frame_start  out  one-clock pulse after the advance into (0,0)
//   vblank_irq   out  sticky flag set on entry to the vertical front porch
//   irq_ack      in   clears vblank_irq
// Optional feature: define VGA_TIMING_VBLANK_IRQ_EN to add vblank_irq and
// irq_ack. Without it those ports and the flag logic do not exist.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FRONT   = DEF_H_FRONT,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BACK    = DEF_H_BACK,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FRONT   = DEF_V_FRONT,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BACK    = DEF_V_BACK,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   X_W       = 10,
  parameter int   Y_W       = 10
) (
  input  logic           clk,
  input  logic           rst,
`ifdef VGA_TIMING_VBLANK_IRQ_EN
  input  logic           irq_ack,
  output logic           vblank_irq,
`endif
  input  logic           pix_en,
  output logic           hsync,
  output logic           vsync,
  output logic           active,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           frame_start
);

  logic       hWrap, vWrap, vStep;
  logic [1:0] hPhase, vPhase, hPhaseNext, vPhaseNext;

  // The vertical axis moves only when the horizontal axis wraps.
  assign vStep = pix_en & hWrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(X_W)
  ) uHAxis (
    .clk(clk), .rst(rst), .step(pix_en),
    .count(x), .phase(hPhase), .nextPhase(hPhaseNext), .wrap(hWrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(Y_W)
  ) uVAxis (
    .clk(clk), .rst(rst), .step(vStep),
    .count(y), .phase(vPhase), .nextPhase(vPhaseNext), .wrap(vWrap)
  );

  // Decoded outputs are taken from the current phases only to keep them
  // observable; the registers below work from the next phases.
  logic unusedPhase;
  assign unusedPhase = ^{hPhase, vPhase};

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic active_q, active_d;
  logic frameStart_q, frameStart_d;

  // Decode from the axes' next phases so the registered outputs change on
  // the same edge as x/y. With pix_en low the next phases equal the current
  // ones, so everything holds; frame_start is a pulse and drops back to 0.
  always_comb begin
    hsync_d      = (hPhaseNext == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d      = (vPhaseNext == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
    active_d     = (hPhaseNext == PH_ACTIVE) && (vPhaseNext == PH_ACTIVE);
    frameStart_d = pix_en & hWrap & vWrap;
  end

  // Output registers, reset to the deasserted/idle levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q      <= ~HSYNC_POL;
      vsync_q      <= ~VSYNC_POL;
      active_q     <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      active_q     <= active_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign frame_start = frameStart_q;

`ifdef VGA_TIMING_VBLANK_IRQ_EN
  localparam logic [Y_W-1:0] V_IRQ_ROW = Y_W'(V_ACTIVE - 1);

  logic irqSet;
  logic vblankIrq_q, vblankIrq_d;

  // The flag sets on the advance into (0, V_ACTIVE). A set on the same edge
  // as an acknowledge wins, so that new event is not lost.
  always_comb begin
    irqSet      = pix_en & hWrap & (y == V_IRQ_ROW);
    vblankIrq_d = vblankIrq_q;
    if (irqSet) begin
      vblankIrq_d = 1'b1;
    end else if (irq_ack) begin
      vblankIrq_d = 1'b0;
    end
  end

  // Sticky interrupt flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblankIrq_q <= 1'b0;
    end else begin
      vblankIrq_q <= vblankIrq_d;
    end
  end

  assign vblank_irq = vblankIrq_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing
// Bench for vga_timing. The main instance uses the default 640x480 timing.
// A second, miniature instance (15x10 raster, hsync active high) covers
// whole-frame behaviour, mid-frame reset and the optional vblank IRQ
// (VGA_TIMING_VBLANK_IRQ_EN) in few cycles.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main (640x480) instance
  logic       rst, pixEn;
  logic       hsyncM, vsyncM, activeM, fsM;
  logic [9:0] xM, yM;
`ifdef VGA_TIMING_VBLANK_IRQ_EN
  logic       ackM, irqM;
`endif

  vga_timing uDut (
    .clk(clk), .rst(rst),
`ifdef VGA_TIMING_VBLANK_IRQ_EN
    .irq_ack(ackM), .vblank_irq(irqM),
`endif
    .pix_en(pixEn), .hsync(hsyncM), .vsync(vsyncM), .active(activeM),
    .x(xM), .y(yM), .frame_start(fsM)
  );

  // Miniature instance: H 8/2/3/2 (total 15), V 6/1/2/1 (total 10)
  logic       rstS, pixEnS;
  logic       hsyncS, vsyncS, activeS, fsS;
  logic [3:0] xS, yS;
`ifdef VGA_TIMING_VBLANK_IRQ_EN
  logic       ackS, irqS;
`endif

  vga_timing #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .X_W(4), .Y_W(4)
  ) uDutS (
    .clk(clk), .rst(rstS),
`ifdef VGA_TIMING_VBLANK_IRQ_EN
    .irq_ack(ackS), .vblank_irq(irqS),
`endif
    .pix_en(pixEnS), .hsync(hsyncS), .vsync(vsyncS), .active(activeS),
    .x(xS), .y(yS), .frame_start(fsS)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string name;
    int    x;
    int    y;
    logic  hs;
    logic  vs;
    logic  act;
    logic  fs;
  } exp_t;

  exp_t sbq[$];
  exp_t monItem;

  // Reference position of the main instance
  int   mX, mY;
  logic mFs;

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Drive pix_en for the next rising edge and advance the reference position.
  task automatic applyStimulus(input logic en);
    @(negedge clk);
    pixEn = en;
    mFs   = 1'b0;
    if (en) begin
      if (mX == 799) begin
        mX = 0;
        mY = (mY == 524) ? 0 : mY + 1;
      end else begin
        mX = mX + 1;
      end
      mFs = (mX == 0) && (mY == 0);
    end
  endtask

  task automatic expectConst(input string name, input int ex, input int ey,
                             input logic hs, input logic vs,
                             input logic act, input logic fs);
    exp_t e;
    e.name = name; e.x = ex; e.y = ey;
    e.hs = hs; e.vs = vs; e.act = act; e.fs = fs;
    sbq.push_back(e);
  endtask

  // Expected outputs straight from the 640x480 timing table (POL = 0).
  task automatic expectModel(input string name);
    exp_t e;
    e.name = name; e.x = mX; e.y = mY;
    e.hs  = !((mX >= 656) && (mX < 752));
    e.vs  = !((mY >= 490) && (mY < 492));
    e.act = (mX < 640) && (mY < 480);
    e.fs  = mFs;
    sbq.push_back(e);
  endtask

  // Monitor: one expectation per clock, compared after the edge has settled.
  always @(posedge clk) begin
    #1;
    if (sbq.size() != 0) begin
      monItem = sbq.pop_front();
      checkOutput({monItem.name, ".x"},   32'(xM),      32'(monItem.x));
      checkOutput({monItem.name, ".y"},   32'(yM),      32'(monItem.y));
      checkOutput({monItem.name, ".hs"},  32'(hsyncM),  32'(monItem.hs));
      checkOutput({monItem.name, ".vs"},  32'(vsyncM),  32'(monItem.vs));
      checkOutput({monItem.name, ".act"}, 32'(activeM), 32'(monItem.act));
      checkOutput({monItem.name, ".fs"},  32'(fsM),     32'(monItem.fs));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: got no finish, want finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int   cyc, actCnt, vsLow, hsHigh, yMin, yMax;
    logic gotFs;

    rst = 1'b1; pixEn = 1'b0; rstS = 1'b1; pixEnS = 1'b0;
`ifdef VGA_TIMING_VBLANK_IRQ_EN
    ackM = 1'b0; ackS = 1'b0;
`endif
    mX = 799; mY = 524; mFs = 1'b0;

    // Reset state of both instances
    repeat (3) @(negedge clk);
    checkOutput("rst.x",   32'(xM),      32'd799);
    checkOutput("rst.y",   32'(yM),      32'd524);
    checkOutput("rst.hs",  32'(hsyncM),  32'd1);
    checkOutput("rst.vs",  32'(vsyncM),  32'd1);
    checkOutput("rst.act", 32'(activeM), 32'd0);
    checkOutput("rst.fs",  32'(fsM),     32'd0);
    checkOutput("sRst.x",  32'(xS),      32'd14);
    checkOutput("sRst.y",  32'(yS),      32'd9);
    checkOutput("sRst.hs", 32'(hsyncS),  32'd0);
`ifdef VGA_TIMING_VBLANK_IRQ_EN
    checkOutput("rst.irq", 32'(irqM), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // First pixel after reset lands on (0,0) with frame_start
    applyStimulus(1'b1); expectConst("first",  0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0); expectConst("fsDrop", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);

    // One line at pix_en every second clock, checking the porch/sync edges
    for (int i = 1; i < 800; i++) begin
      applyStimulus(1'b1);
      case (i)
        640: expectConst("x640", 640, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        655: expectConst("x655", 655, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        656: expectConst("x656", 656, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        751: expectConst("x751", 751, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        752: expectConst("x752", 752, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        799: expectConst("x799", 799, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        default: if (i % 50 == 0) expectModel("lineModel");
      endcase
      applyStimulus(1'b0);
    end
    applyStimulus(1'b1); expectConst("lineWrap", 0, 1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Stall for 50 clocks at x=100: everything frozen
    repeat (99) applyStimulus(1'b1);
    applyStimulus(1'b1); expectConst("preStall", 100, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (50) begin
      applyStimulus(1'b0); expectConst("stall", 100, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    applyStimulus(1'b1); expectConst("resume", 101, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0);

    // Miniature raster: release reset with pix_en tied high
    @(negedge clk);
    rstS = 1'b0; pixEnS = 1'b1;
    @(posedge clk); #1;
    checkOutput("sFirst.x",  32'(xS),      32'd0);
    checkOutput("sFirst.y",  32'(yS),      32'd0);
    checkOutput("sFirst.fs", 32'(fsS),     32'd1);
    checkOutput("sFirst.hs", 32'(hsyncS),  32'd0);
    checkOutput("sFirst.act",32'(activeS), 32'd1);

    // Measure one full frame between frame_start pulses
    cyc = 0; actCnt = 0; vsLow = 0; hsHigh = 0; yMin = 99; yMax = -1;
    gotFs = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (activeS) actCnt++;
      if (hsyncS) hsHigh++;
      if (!vsyncS) begin
        vsLow++;
        if (int'(yS) < yMin) yMin = int'(yS);
        if (int'(yS) > yMax) yMax = int'(yS);
      end
      cyc++;
      @(posedge clk); #1;
      if (fsS) begin
        gotFs = 1'b1;
        break;
      end
    end
    checkOutput("sFrameFs",     32'(gotFs),  32'd1);
    checkOutput("sFramePeriod", 32'(cyc),    32'd150);
    checkOutput("sActiveCnt",   32'(actCnt), 32'd48);
    checkOutput("sHsyncCnt",    32'(hsHigh), 32'd30);
    checkOutput("sVsyncCnt",    32'(vsLow),  32'd30);
    checkOutput("sVsyncYMin",   32'(yMin),   32'd7);
    checkOutput("sVsyncYMax",   32'(yMax),   32'd8);

    // Advance to (5,3) then reset asynchronously between clock edges
    repeat (50) begin
      @(posedge clk); #1;
    end
    checkOutput("sPreRst.x",   32'(xS),      32'd5);
    checkOutput("sPreRst.y",   32'(yS),      32'd3);
    checkOutput("sPreRst.act", 32'(activeS), 32'd1);
`ifdef VGA_TIMING_VBLANK_IRQ_EN
    checkOutput("sPreRst.irq", 32'(irqS), 32'd1);
`endif
    #2;
    rstS = 1'b1; pixEnS = 1'b0;
    #1;
    checkOutput("sAsyncRst.x",   32'(xS),      32'd14);
    checkOutput("sAsyncRst.y",   32'(yS),      32'd9);
    checkOutput("sAsyncRst.hs",  32'(hsyncS),  32'd0);
    checkOutput("sAsyncRst.vs",  32'(vsyncS),  32'd1);
    checkOutput("sAsyncRst.act", 32'(activeS), 32'd0);
`ifdef VGA_TIMING_VBLANK_IRQ_EN
    checkOutput("sAsyncRst.irq", 32'(irqS), 32'd0);
`endif
    repeat (2) @(negedge clk);
    @(negedge clk);
    rstS = 1'b0; pixEnS = 1'b1;
    @(posedge clk); #1;
    checkOutput("sAfterRst.x",  32'(xS),  32'd0);
    checkOutput("sAfterRst.y",  32'(yS),  32'd0);
    checkOutput("sAfterRst.fs", 32'(fsS), 32'd1);

`ifdef VGA_TIMING_VBLANK_IRQ_EN
    // 90 more pixels reach (0,6); ack on that same edge must not clear it
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      ackS = (i == 90);
      @(posedge clk); #1;
      if (i == 89) checkOutput("irqBefore", 32'(irqS), 32'd0);
      if (i == 90) begin
        checkOutput("irqSet",   32'(irqS), 32'd1);
        checkOutput("irqSet.y", 32'(yS),   32'd6);
        checkOutput("irqSet.x", 32'(xS),   32'd0);
      end
    end
    @(negedge clk);
    pixEnS = 1'b0; ackS = 1'b0;
    @(posedge clk); #1;
    checkOutput("irqHeld", 32'(irqS), 32'd1);
    @(negedge clk);
    ackS = 1'b1;
    @(posedge clk); #1;
    checkOutput("irqAck", 32'(irqS), 32'd0);
    @(negedge clk);
    ackS = 1'b0;
    checkOutput("mIrqIdle", 32'(irqM), 32'd0);
`endif

    repeat (2) @(negedge clk);
    checkOutput("sbDrained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
